// File: rtl/srp_buf_pkg.sv
// Shared types, default sizes and address helper for the SRP sample buffer.
package srp_buf_pkg;

    localparam int DEPTH_DEF     = 2096;
    localparam int AW_DEF        = 12;
    localparam int DW_DEF        = 32;
    localparam int FRAME_LEN_DEF = 2048;

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        POST    = 2'd1,
        READ    = 2'd2
    } state_t;

    // Next ring-buffer address: wraps from depth-1 back to 0.
    function automatic logic [31:0] wrap_inc(input logic [31:0] addr, input logic [31:0] depth);
        return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/srp_out_skid.sv
// Two-entry fall-through output buffer between the BRAM read port and the
// frame stream. When empty, the word arriving from the BRAM is presented
// directly; if it is not taken it is stored, so the head never changes while
// out_valid=1 and out_ready=0. count is the stored occupancy (0..2).
module srp_out_skid #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic [1:0]    count
);

    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          l0;
    logic          l1;
    logic          pop;

    assign out_valid = (count != 2'd0) || in_valid;
    assign out_data  = (count != 2'd0) ? d0 : in_data;
    assign out_last  = (count != 2'd0) ? l0 : in_last;
    assign pop       = out_valid && out_ready;

    // Storage update: keep the head as d0, append behind it, shift on pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            d0    <= '0;
            d1    <= '0;
            l0    <= 1'b0;
            l1    <= 1'b0;
        end else begin
            case (count)
                2'd0: begin
                    if (in_valid && !out_ready) begin
                        d0    <= in_data;
                        l0    <= in_last;
                        count <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && in_valid) begin
                        d0 <= in_data;
                        l0 <= in_last;
                    end else if (pop) begin
                        count <= 2'd0;
                    end else if (in_valid) begin
                        d1    <= in_data;
                        l1    <= in_last;
                        count <= 2'd2;
                    end
                end
                default: begin
                    if (pop) begin
                        d0 <= d1;
                        l0 <= l1;
                        if (in_valid) begin
                            d1 <= in_data;
                            l1 <= in_last;
                        end else begin
                            count <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/srp_buffer_ctrl.sv
// Sample BRAM owner for the SRP time synchronizer: ring-buffer capture of the
// ADC stream, post-sync fill, then one frame read back as a stream with last.
//
// Handshakes: a beat transfers on a rising edge where valid and ready are both
// high. Once valid is raised, data/last stay stable until the beat transfers;
// ready may change freely and never depends combinationally on valid.
module srp_buffer_ctrl
    import srp_buf_pkg::*;
#(
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          sync_hit,
    input  logic [AW-1:0] sync_idx,
    output logic          bram_en,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    output logic [DW-1:0] bram_di,
    input  logic [DW-1:0] bram_dout,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          busy,
    output logic          hit_drop,
    output logic [1:0]    dbg_state
);

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] end_ptr;
    logic [AW-1:0] wr_next;
    logic [AW-1:0] end_calc;
    logic [AW:0]   rd_cnt;
    logic [AW:0]   end_sum;
    logic          rd_pend;
    logic          rd_pend_last;
    logic          wr_fire;
    logic          rd_issue;
    logic [1:0]    occ;

    assign s_ready = (state != READ);
    assign wr_fire = s_valid && s_ready;

    // A read needs room for its word: stored words plus the one in flight.
    assign rd_issue = (state == READ) && (rd_cnt < (AW+1)'(FRAME_LEN))
                      && ((occ + {1'b0, rd_pend}) < 2'd2);

    assign bram_en   = wr_fire || rd_issue;
    assign bram_we   = wr_fire;
    assign bram_addr = rd_issue ? rd_ptr : wr_ptr;
    assign bram_di   = s_data;

    assign wr_next  = wr_fire ? AW'(wrap_inc(32'(wr_ptr), 32'(DEPTH))) : wr_ptr;
    // sync_idx and FRAME_LEN are both below DEPTH, so one subtraction wraps.
    assign end_sum  = {1'b0, sync_idx} + (AW+1)'(FRAME_LEN);
    assign end_calc = (end_sum >= (AW+1)'(DEPTH)) ? AW'(end_sum - (AW+1)'(DEPTH))
                                                  : AW'(end_sum);

    assign dbg_state = state;

    srp_out_skid #(.DW(DW)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rd_pend),
        .in_data   (bram_dout),
        .in_last   (rd_pend_last),
        .out_valid (m_valid),
        .out_data  (m_data),
        .out_last  (m_last),
        .out_ready (m_ready),
        .count     (occ)
    );

    // Capture/post/read sequencing with pointers and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= CAPTURE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            end_ptr      <= '0;
            rd_cnt       <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            busy         <= 1'b0;
            hit_drop     <= 1'b0;
        end else begin
            wr_ptr       <= wr_next;
            rd_pend      <= rd_issue;
            rd_pend_last <= rd_issue && (rd_cnt == (AW+1)'(FRAME_LEN - 1));
            hit_drop     <= sync_hit && (state != CAPTURE);
            if (rd_issue) begin
                rd_ptr <= AW'(wrap_inc(32'(rd_ptr), 32'(DEPTH)));
                rd_cnt <= rd_cnt + 1'b1;
            end
            case (state)
                CAPTURE: begin
                    if (sync_hit) begin
                        end_ptr <= end_calc;
                        rd_ptr  <= sync_idx;
                        rd_cnt  <= '0;
                        state   <= POST;
                        busy    <= 1'b1;
                    end
                end
                POST: begin
                    // Equal on entry, or reached by this cycle's write.
                    if ((wr_ptr == end_ptr) || (wr_next == end_ptr)) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (m_valid && m_ready && m_last) begin
                        state <= CAPTURE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= CAPTURE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srp_buffer_ctrl.sv
// Bench for srp_buffer_ctrl with a small BRAM model and an address-level
// reference of what the frame must contain.
module tb_srp_buffer_ctrl;
    import srp_buf_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int FL    = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          sync_hit;
    logic [AW-1:0] sync_idx;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_di;
    logic [DW-1:0] bram_dout;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;
    logic          busy;
    logic          hit_drop;
    logic [1:0]    dbg_state;

    srp_buffer_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .sync_hit  (sync_hit),
        .sync_idx  (sync_idx),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_di   (bram_di),
        .bram_dout (bram_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .busy      (busy),
        .hit_drop  (hit_drop),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- BRAM model: registered read ----------------
    logic [DW-1:0] bram_mem [DEPTH];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) bram_mem[bram_addr] <= bram_di;
            else         bram_dout <= bram_mem[bram_addr];
        end
    end

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] ref_mem [DEPTH];
    logic [AW-1:0] exp_q[$];
    int            mdl_wr;
    int            acc_cnt;
    int            beats_out;
    int            seq;
    int            ready_mode;
    int            ph;
    int            n_checks;
    int            n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Watches both sides of the DUT every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!bram_en) check("we_without_en", 64'(bram_we), 64'(0));
            if (bram_en && !bram_we) check("read_only_in_read", 64'(s_ready), 64'(0));
            if (s_valid && s_ready) begin
                check("wr_en", 64'({bram_en, bram_we}), 64'(2'b11));
                check("wr_addr", 64'(bram_addr), 64'(mdl_wr));
                check("wr_data", 64'(bram_di), 64'(s_data));
                ref_mem[mdl_wr] = s_data;
                mdl_wr = (mdl_wr + 1) % DEPTH;
                acc_cnt++;
            end
            if (m_valid) begin
                check("s_ready_in_read", 64'(s_ready), 64'(0));
                check("busy_in_read", 64'(busy), 64'(1));
                if (exp_q.size() == 0) begin
                    check("m_unexpected", 64'(m_valid), 64'(0));
                end else begin
                    check("m_data", 64'(m_data), 64'(ref_mem[exp_q[0]]));
                    check("m_last", 64'(m_last), 64'(exp_q.size() == 1));
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        beats_out++;
                    end
                end
            end
        end
    end

    // m_ready driver: 0 = always ready, 1 = random, 2 = pattern 1,0,0,1.
    initial begin
        m_ready = 1'b1;
        ph = 0;
        forever begin
            @(posedge clk);
            #1;
            ph++;
            case (ready_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic write_beat(input logic [DW-1:0] d, input bit gaps);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        if (gaps && ($urandom_range(0, 3) == 0)) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        mdl_wr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic do_frame(input int pre, input int idx, input int mode,
                            input bit drop, input bit rst_mid, input bit seqd);
        int needed;
        int t;
        int snap;
        ready_mode = mode;
        for (int i = 0; i < pre; i++) begin
            write_beat(seqd ? DW'(seq) : DW'($urandom), 1'b1);
            seq++;
        end
        needed = (((idx + FL) % DEPTH) - mdl_wr + DEPTH) % DEPTH;
        for (int k = 0; k < FL; k++) exp_q.push_back(AW'((idx + k) % DEPTH));
        beats_out = 0;
        sync_idx = AW'(idx);
        sync_hit = 1'b1;
        @(posedge clk);
        #1;
        sync_hit = 1'b0;
        snap = acc_cnt;
        for (int i = 0; i < needed; i++) begin
            write_beat(seqd ? DW'(seq) : DW'($urandom), 1'b1);
            seq++;
        end
        t = 0;
        while (!m_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("m_valid_rise", 64'(m_valid), 64'(1));
        check("post_beats", 64'(acc_cnt - snap), 64'(needed));
        check("state_read", 64'(dbg_state), 64'(READ));
        if (drop) begin
            @(posedge clk);
            #1;
            sync_hit = 1'b1;
            sync_idx = AW'($urandom);
            @(posedge clk);
            #1;
            sync_hit = 1'b0;
            @(negedge clk);
            check("hit_drop_pulse", 64'(hit_drop), 64'(1));
            @(negedge clk);
            check("hit_drop_clear", 64'(hit_drop), 64'(0));
        end
        if (rst_mid) begin
            @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check("rst_m_valid", 64'(m_valid), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_s_ready", 64'(s_ready), 64'(1));
            check("rst_state", 64'(dbg_state), 64'(CAPTURE));
            exp_q.delete();
            mdl_wr = 0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            ready_mode = 0;
            return;
        end
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("frame_drain", 64'(exp_q.size()), 64'(0));
        check("frame_beats", 64'(beats_out), 64'(FL));
        @(posedge clk);
        @(negedge clk);
        check("cap_s_ready", 64'(s_ready), 64'(1));
        check("cap_busy", 64'(busy), 64'(0));
        check("cap_state", 64'(dbg_state), 64'(CAPTURE));
        exp_q.delete();
        ready_mode = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        sync_hit   = 1'b0;
        sync_idx   = '0;
        ready_mode = 0;
        mdl_wr     = 0;
        acc_cnt    = 0;
        beats_out  = 0;
        seq        = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_m_valid", 64'(m_valid), 64'(0));
        check("reset_m_last", 64'(m_last), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_hit_drop", 64'(hit_drop), 64'(0));
        check("reset_s_ready", 64'(s_ready), 64'(1));
        check("reset_state", 64'(dbg_state), 64'(CAPTURE));
        rst_n = 1'b1;

        // Basic frame: samples 0..9, hit at 6, READ without a POST wait.
        for (int i = 0; i < 10; i++) write_beat(DW'(i), 1'b0);
        for (int k = 0; k < FL; k++) exp_q.push_back(AW'(6 + k));
        beats_out = 0;
        sync_idx = AW'(6);
        sync_hit = 1'b1;
        @(posedge clk);
        #1;
        sync_hit = 1'b0;
        @(negedge clk);
        check("basic_post_no_valid", 64'(m_valid), 64'(0));
        check("basic_busy", 64'(busy), 64'(1));
        @(negedge clk);
        check("basic_issue_no_valid", 64'(m_valid), 64'(0));
        @(negedge clk);
        check("basic_first_valid", 64'(m_valid), 64'(1));
        repeat (3) @(negedge clk);
        check("basic_last_cycle", 64'(m_valid && m_last), 64'(1));
        @(negedge clk);
        check("basic_back_capture", 64'(s_ready), 64'(1));
        check("basic_beats", 64'(beats_out), 64'(FL));

        // POST wait: samples 0..9, hit at 8, frame needs samples 10 and 11.
        do_reset();
        seq = 0;
        for (int i = 0; i < 10; i++) begin
            write_beat(DW'(seq), 1'b0);
            seq++;
        end
        do_frame(0, 8, 0, 1'b0, 1'b0, 1'b1);

        // Fill the whole ring with random samples.
        for (int i = 0; i < DEPTH; i++) write_beat(DW'($urandom), 1'b1);

        // Wrap-around frame at 14,15,0,1.
        do_frame(int'($urandom_range(0, 5)), 14, 0, 1'b0, 1'b0, 1'b0);
        // Backpressure pattern 1,0,0,1.
        do_frame(int'($urandom_range(0, 8)), int'($urandom_range(0, DEPTH - 1)), 2, 1'b0, 1'b0, 1'b0);
        // Ignored hit during READ.
        do_frame(int'($urandom_range(0, 8)), int'($urandom_range(0, DEPTH - 1)), 0, 1'b1, 1'b0, 1'b0);
        // Reset in the middle of READ; writing restarts at address 0.
        do_frame(3, int'($urandom_range(0, DEPTH - 1)), 1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) write_beat(DW'($urandom), 1'b0);

        // Randomised frames.
        for (int f = 0; f < 20; f++) begin
            do_frame(int'($urandom_range(0, 20)), int'($urandom_range(0, DEPTH - 1)),
                     int'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0), 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
